// File: rtl/pads_in_cond_pkg.sv
// Shared constants for the input pad conditioning block.
// Reset idle levels for the serial lines and the default timing parameters,
// also used by the pad-ring testbenches.
package pads_in_cond_pkg;

    // Level each synchronizer chain holds while in reset.
    localparam logic UART_IDLE = 1'b1;  // UART line idles high
    localparam logic MISO_IDLE = 1'b0;

    // Default block configuration.
    localparam int unsigned DEF_N_BTN           = 4;
    localparam int unsigned DEF_SYNC_STAGES     = 2;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 50000;
    localparam int unsigned DEF_CNT_W           = 16;

endpackage

// File: rtl/pads_in_cond_debounce_cell.sv
// debounce_cell: conditioning path for one push-button bit.
// Synchronizes the asynchronous pad level, requires DEBOUNCE_CYCLES
// consecutive samples that differ from the accepted level before taking the
// new level, and emits a one-cycle registered pulse on each accepted edge.
// Ports:
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset
//   pad    in   raw button level from pad, asynchronous
//   level  out  debounced button level
//   rise   out  one-cycle pulse when level goes 0->1
//   fall   out  one-cycle pulse when level goes 1->0
module debounce_cell #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned CNT_W           = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pad,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic [CNT_W-1:0]       cnt;
    logic                   s;

    assign s = sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync  <= '0;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], pad};
            rise <= 1'b0;
            fall <= 1'b0;
            if (s == level) begin
                // Any matching sample restarts the stability count.
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                // DEBOUNCE_CYCLES-th consecutive differing sample: accept it.
                level <= s;
                cnt   <= '0;
                rise  <= s;
                fall  <= ~s;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pads_in_cond.sv
// pads_in_cond: input-side conditioning between the pad cells and the core.
// uart_sin and spi_miso pass through plain synchronizer chains; each push
// button gets a synchronizer, debounce counter and edge-pulse generator.
// All outputs are in the clk domain.
// Ports:
//   clk            in   system clock
//   rst_n          in   asynchronous active-low reset
//   uart_sin_pad   in   UART serial input from pad, asynchronous
//   spi_miso_pad   in   SPI MISO from pad, asynchronous
//   btn_pad        in   push buttons from pad, asynchronous, active-high
//   uart_sin_core  out  synchronized UART input
//   spi_miso_core  out  synchronized MISO
//   btn_core       out  debounced button levels
//   btn_rise       out  one-cycle pulse per bit when btn_core goes 0->1
//   btn_fall       out  one-cycle pulse per bit when btn_core goes 1->0
module pads_in_cond
    import pads_in_cond_pkg::*;
#(
    parameter int unsigned N_BTN           = DEF_N_BTN,
    parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned CNT_W           = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             uart_sin_pad,
    input  logic             spi_miso_pad,
    input  logic [N_BTN-1:0] btn_pad,
    output logic             uart_sin_core,
    output logic             spi_miso_core,
    output logic [N_BTN-1:0] btn_core,
    output logic [N_BTN-1:0] btn_rise,
    output logic [N_BTN-1:0] btn_fall
);

`ifndef SYNTHESIS
    if (SYNC_STAGES < 2) begin : g_bad_sync_stages
        $error("pads_in_cond: SYNC_STAGES must be >= 2");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce_cycles
        $error("pads_in_cond: DEBOUNCE_CYCLES must be >= 1");
    end
    if (longint'(DEBOUNCE_CYCLES) >= (longint'(1) << CNT_W)) begin : g_bad_cnt_w
        $error("pads_in_cond: CNT_W too narrow for DEBOUNCE_CYCLES");
    end
`endif

    logic [SYNC_STAGES-1:0] uart_sync;
    logic [SYNC_STAGES-1:0] miso_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            uart_sync <= {SYNC_STAGES{UART_IDLE}};
            miso_sync <= {SYNC_STAGES{MISO_IDLE}};
        end else begin
            uart_sync <= {uart_sync[SYNC_STAGES-2:0], uart_sin_pad};
            miso_sync <= {miso_sync[SYNC_STAGES-2:0], spi_miso_pad};
        end
    end

    assign uart_sin_core = uart_sync[SYNC_STAGES-1];
    assign spi_miso_core = miso_sync[SYNC_STAGES-1];

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        debounce_cell #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_cell (
            .clk  (clk),
            .rst_n(rst_n),
            .pad  (btn_pad[i]),
            .level(btn_core[i]),
            .rise (btn_rise[i]),
            .fall (btn_fall[i])
        );
    end

endmodule

// File: tb/tb_pads_in_cond.sv
// Self-checking bench for pads_in_cond with SYNC_STAGES=2, DEBOUNCE_CYCLES=8.
// The reference model keeps a history of pad samples (for synchronizer delay)
// and a sliding window of the last DEBOUNCE_CYCLES synchronized button
// samples: a button level flips when every sample in the window differs
// from the current level.
module tb_pads_in_cond;

    localparam int N = 4;
    localparam int S = 2;
    localparam int D = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         uart_sin_pad = 1'b1;
    logic         spi_miso_pad = 1'b0;
    logic [N-1:0] btn_pad = '0;
    logic         uart_sin_core;
    logic         spi_miso_core;
    logic [N-1:0] btn_core;
    logic [N-1:0] btn_rise;
    logic [N-1:0] btn_fall;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pads_in_cond #(
        .N_BTN          (N),
        .SYNC_STAGES    (S),
        .DEBOUNCE_CYCLES(D),
        .CNT_W          (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .uart_sin_pad (uart_sin_pad),
        .spi_miso_pad (spi_miso_pad),
        .btn_pad      (btn_pad),
        .uart_sin_core(uart_sin_core),
        .spi_miso_core(spi_miso_core),
        .btn_core     (btn_core),
        .btn_rise     (btn_rise),
        .btn_fall     (btn_fall)
    );

    // ---------------- reference model ----------------
    logic [N+1:0] hist[$];   // pad samples {btn, miso, uart}, newest first
    logic [N-1:0] win[$];    // synchronized button samples, newest first
    logic [N-1:0] m_level, m_rise, m_fall;
    logic         m_uart, m_miso;

    function automatic void model_reset();
        hist.delete();
        for (int i = 0; i <= S; i++) hist.push_back({{N{1'b0}}, 1'b0, 1'b1});
        win.delete();
        for (int i = 0; i < D; i++) win.push_back('0);
        m_level = '0;
        m_rise  = '0;
        m_fall  = '0;
        m_uart  = 1'b1;
        m_miso  = 1'b0;
    endfunction

    function automatic void model_edge(logic [N+1:0] p);
        logic [N+1:0] old;
        logic [N-1:0] s;
        logic         all_diff;
        hist.push_front(p);
        while (hist.size() > S + 1) void'(hist.pop_back());
        old = hist[S];
        s = old[N+1:2];
        win.push_front(s);
        while (win.size() > D) void'(win.pop_back());
        m_rise = '0;
        m_fall = '0;
        for (int i = 0; i < N; i++) begin
            all_diff = 1'b1;
            foreach (win[j]) begin
                if (win[j][i] == m_level[i]) all_diff = 1'b0;
            end
            if (all_diff) begin
                m_level[i] = ~m_level[i];
                if (m_level[i]) m_rise[i] = 1'b1;
                else            m_fall[i] = 1'b1;
            end
        end
        old = hist[S-1];
        m_uart = old[0];
        m_miso = old[1];
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("uart_core", 32'(uart_sin_core), 32'(m_uart));
        chk("miso_core", 32'(spi_miso_core), 32'(m_miso));
        chk("btn_core",  32'(btn_core), 32'(m_level));
        chk("btn_rise",  32'(btn_rise), 32'(m_rise));
        chk("btn_fall",  32'(btn_fall), 32'(m_fall));
    endtask

    // One clock: reset level applied at negedge, pads as currently driven.
    task automatic tick(input logic r);
        @(negedge clk);
        rst_n = r;
        if (!r) begin
            #1;
            model_reset();
            compare_all();
        end
        @(posedge clk);
        if (r) model_edge({btn_pad, spi_miso_pad, uart_sin_pad});
        #1;
        compare_all();
    endtask

    task automatic run_track(input int n, input int b, input logic want,
                             output int first, output int rises, output int falls);
        first = -1;
        rises = 0;
        falls = 0;
        for (int k = 1; k <= n; k++) begin
            tick(1'b1);
            if (first < 0 && btn_core[b] == want) first = k;
            rises += int'(btn_rise[b]);
            falls += int'(btn_fall[b]);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int f, r, fl, lat_u, lat_m, tot_r;
        model_reset();

        // 1. reset held with random pads
        for (int k = 0; k < 6; k++) begin
            uart_sin_pad = 1'($urandom);
            spi_miso_pad = 1'($urandom);
            btn_pad      = N'($urandom);
            tick(1'b0);
        end
        chk("rst_uart", 32'(uart_sin_core), 32'd1);
        chk("rst_miso", 32'(spi_miso_core), 32'd0);
        chk("rst_btn",  32'(btn_core), 32'd0);
        chk("rst_puls", 32'({btn_rise, btn_fall}), 32'd0);

        // settle at idle levels out of reset
        uart_sin_pad = 1'b1;
        spi_miso_pad = 1'b0;
        btn_pad      = '0;
        for (int k = 0; k < 4; k++) tick(1'b1);

        // 2. synchronizer latency
        uart_sin_pad = 1'b0;
        spi_miso_pad = 1'b1;
        lat_u = -1;
        lat_m = -1;
        for (int k = 1; k <= 10; k++) begin
            tick(1'b1);
            if (lat_u < 0 && uart_sin_core == 1'b0) lat_u = k;
            if (lat_m < 0 && spi_miso_core == 1'b1) lat_m = k;
        end
        chk("uart_latency", 32'(lat_u), 32'd2);
        chk("miso_latency", 32'(lat_m), 32'd2);
        uart_sin_pad = 1'b1;
        spi_miso_pad = 1'b0;

        // 3. clean press and release on bit 0
        btn_pad[0] = 1'b1;
        run_track(20, 0, 1'b1, f, r, fl);
        chk("press_latency", 32'(f), 32'd10);
        chk("press_rises",   32'(r), 32'd1);
        chk("press_falls",   32'(fl), 32'd0);
        btn_pad[0] = 1'b0;
        run_track(20, 0, 1'b0, f, r, fl);
        chk("release_latency", 32'(f), 32'd10);
        chk("release_falls",   32'(fl), 32'd1);
        chk("release_rises",   32'(r), 32'd0);

        // 4. 7-cycle glitch on bit 1 is rejected, then a full press needs 10 cycles
        btn_pad[1] = 1'b1;
        run_track(7, 1, 1'b1, f, r, fl);
        chk("glitch_core", 32'(f), 32'hffff_ffff);
        btn_pad[1] = 1'b0;
        run_track(10, 1, 1'b1, f, r, fl);
        chk("glitch_after", 32'(f), 32'hffff_ffff);
        chk("glitch_rises", 32'(r), 32'd0);
        btn_pad[1] = 1'b1;
        run_track(12, 1, 1'b1, f, r, fl);
        chk("post_glitch_latency", 32'(f), 32'd10);
        btn_pad[1] = 1'b0;
        run_track(12, 1, 1'b0, f, r, fl);

        // 5. bouncing press on bit 2
        tot_r = 0;
        for (int rep = 0; rep < 5; rep++) begin
            btn_pad[2] = 1'b1;
            run_track(3, 2, 1'b1, f, r, fl);
            tot_r += r;
            btn_pad[2] = 1'b0;
            run_track(2, 2, 1'b1, f, r, fl);
            tot_r += r;
        end
        btn_pad[2] = 1'b1;
        run_track(15, 2, 1'b1, f, r, fl);
        tot_r += r;
        chk("bounce_latency", 32'(f), 32'd10);
        chk("bounce_rises",   32'(tot_r), 32'd1);

        // 6. reset while bit 3 is mid-count (5 differing samples taken)
        btn_pad[3] = 1'b1;
        for (int k = 0; k < 7; k++) tick(1'b1);
        tick(1'b0);
        chk("midrst_core",  32'(btn_core), 32'd0);
        chk("midrst_pulse", 32'({btn_rise, btn_fall}), 32'd0);
        tick(1'b0);
        run_track(15, 3, 1'b1, f, r, fl);
        chk("postrst_latency", 32'(f), 32'd10);
        chk("postrst_rises",   32'(r), 32'd1);

        // randomized phase
        for (int k = 0; k < 3000; k++) begin
            uart_sin_pad = 1'($urandom);
            spi_miso_pad = 1'($urandom);
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 11) == 0) btn_pad[i] = ~btn_pad[i];
            end
            tick(($urandom_range(0, 399) != 0) ? 1'b1 : 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
